// File: rtl/bus_decoder_if.sv
// Memory bus between one core master port, the decoder and N slaves.
// m_* : core request/response (valid, instr, addr, wdata, wstrb / rdata, ready, error).
// s_* : fan-out to slaves. s_valid is one-hot per slave. instr/addr/wdata/wstrb are shared.
//       s_rdata is packed with slave i at [32*i +: 32].
// Modports: master = core side, slave = slave side, dec = the decoder itself.
interface bus_decoder_if #(
    parameter int SLAVES = 6
);
    logic                   m_valid;
    logic                   m_instr;
    logic [31:0]            m_addr;
    logic [31:0]            m_wdata;
    logic [3:0]             m_wstrb;
    logic [31:0]            m_rdata;
    logic                   m_ready;
    logic                   m_error;

    logic [SLAVES-1:0]      s_valid;
    logic                   s_instr;
    logic [31:0]            s_addr;
    logic [31:0]            s_wdata;
    logic [3:0]             s_wstrb;
    logic [32*SLAVES-1:0]   s_rdata;
    logic [SLAVES-1:0]      s_ready;

    modport master (
        output m_valid, m_instr, m_addr, m_wdata, m_wstrb,
        input  m_rdata, m_ready, m_error
    );

    modport slave (
        input  s_valid, s_instr, s_addr, s_wdata, s_wstrb,
        output s_rdata, s_ready
    );

    modport dec (
        input  m_valid, m_instr, m_addr, m_wdata, m_wstrb,
        output m_rdata, m_ready, m_error,
        output s_valid, s_instr, s_addr, s_wdata, s_wstrb,
        input  s_rdata, s_ready
    );
endinterface

// File: rtl/bus_decoder.sv
// Address-mapped router from one memory master to N slaves.
// The decoder holds one outstanding transaction at a time. It answers unmapped
// addresses with an error, and it ends a slave request with an error if the
// slave does not respond within timeout_cycles.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : bus_decoder_if.dec (master request/response and slave fan-out)
// Region i spans [base_addr[32*i +: 32], top_addr[32*i +: 32]).
// A region whose base is not below its top never matches.
module bus_decoder #(
    parameter int                   slaves         = 6,
    parameter logic [32*slaves-1:0] base_addr      = '0,
    parameter logic [32*slaves-1:0] top_addr       = '0,
    parameter int                   timeout_cycles = 256
) (
    input  logic       clock,
    input  logic       reset,
    bus_decoder_if.dec bus
);
    localparam int IW = (slaves > 1) ? $clog2(slaves) : 1;
    localparam int CW = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (timeout_cycles > 0) ? CW'(timeout_cycles - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state_q;
    logic [IW-1:0]      sel_q;
    logic [CW-1:0]      cnt_q;
    logic [slaves-1:0]  s_valid_q;
    logic               s_instr_q;
    logic [31:0]        s_addr_q;
    logic [31:0]        s_wdata_q;
    logic [3:0]         s_wstrb_q;
    logic [31:0]        m_rdata_q;
    logic               m_ready_q;
    logic               m_error_q;

    logic               hit;
    logic [IW-1:0]      hit_idx;
    logic               sel_ready;
    logic [31:0]        sel_rdata;

    // The scan runs from the highest index down, so the lowest matching
    // region is written last and wins when regions overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = slaves - 1; i >= 0; i--) begin
            if ((base_addr[32*i +: 32] < top_addr[32*i +: 32]) &&
                (bus.m_addr >= base_addr[32*i +: 32]) &&
                (bus.m_addr <  top_addr[32*i +: 32])) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Only the selected slave's response counts. Ready from any other slave is ignored.
    assign sel_ready = bus.s_ready[sel_q];
    assign sel_rdata = bus.s_rdata[32*sel_q +: 32];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            s_valid_q <= '0;
            s_instr_q <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wstrb_q <= '0;
            m_rdata_q <= '0;
            m_ready_q <= 1'b0;
            m_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.m_valid) begin
                        if (hit) begin
                            sel_q     <= hit_idx;
                            s_valid_q <= slaves'(1) << hit_idx;
                            s_instr_q <= bus.m_instr;
                            s_addr_q  <= bus.m_addr;
                            s_wdata_q <= bus.m_wdata;
                            s_wstrb_q <= bus.m_wstrb;
                            cnt_q     <= '0;
                            state_q   <= BUSY;
                        end else begin
                            m_rdata_q <= '0;
                            m_error_q <= 1'b1;
                            m_ready_q <= 1'b1;
                            state_q   <= RESP;
                        end
                    end
                end
                // m_valid is not looked at here. Once a request is accepted, it always completes.
                BUSY: begin
                    if (sel_ready) begin
                        s_valid_q <= '0;
                        m_rdata_q <= sel_rdata;
                        m_error_q <= 1'b0;
                        m_ready_q <= 1'b1;
                        state_q   <= RESP;
                    end else if ((timeout_cycles != 0) && (cnt_q == CNT_LAST)) begin
                        s_valid_q <= '0;
                        m_rdata_q <= '0;
                        m_error_q <= 1'b1;
                        m_ready_q <= 1'b1;
                        state_q   <= RESP;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    m_ready_q <= 1'b0;
                    m_error_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_valid = s_valid_q;
    assign bus.s_instr = s_instr_q;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_wdata = s_wdata_q;
    assign bus.s_wstrb = s_wstrb_q;
    assign bus.m_rdata = m_rdata_q;
    assign bus.m_ready = m_ready_q;
    assign bus.m_error = m_error_q;
endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder.
// dut_a: two regions, timeout of 8 cycles.
// dut_b: overlapping regions plus one empty region, timeout disabled.
module tb_bus_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bus_decoder_if #(.SLAVES(2)) bus_a ();
    bus_decoder_if #(.SLAVES(3)) bus_b ();

    bus_decoder #(
        .slaves        (2),
        .base_addr     ({32'h0008_0000, 32'h0000_0000}),
        .top_addr      ({32'h0010_0000, 32'h0008_0000}),
        .timeout_cycles(8)
    ) dut_a (
        .clock(clk),
        .reset(rst),
        .bus  (bus_a)
    );

    bus_decoder #(
        .slaves        (3),
        .base_addr     ({32'h0000_5000, 32'h0000_0800, 32'h0000_0000}),
        .top_addr      ({32'h0000_4000, 32'h0000_2000, 32'h0000_1000}),
        .timeout_cycles(0)
    ) dut_b (
        .clock(clk),
        .reset(rst),
        .bus  (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Invariants checked for both DUTs on every cycle.
    task automatic inv();
        chk("a_onehot",   32'($countones(bus_a.s_valid) <= 1), 32'd1);
        chk("a_err_rdy",  {31'b0, bus_a.m_error & ~bus_a.m_ready}, 32'd0);
        chk("a_err_data", bus_a.m_error ? bus_a.m_rdata : 32'h0, 32'h0);
        chk("b_onehot",   32'($countones(bus_b.s_valid) <= 1), 32'd1);
        chk("b_err_rdy",  {31'b0, bus_b.m_error & ~bus_b.m_ready}, 32'd0);
        chk("b_err_data", bus_b.m_error ? bus_b.m_rdata : 32'h0, 32'h0);
    endtask

    // Inputs are driven, and outputs sampled, 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        inv();
    endtask

    // Read on dut_a where the slave answers in its first s_valid cycle.
    task automatic rd_a(input string tag, input logic [31:0] addr, input logic [1:0] exp_sv,
                        input logic [31:0] data);
        bus_a.m_valid = 1'b1; bus_a.m_addr = addr; bus_a.m_wstrb = 4'h0;
        tick();
        chk({tag, "_sv"}, {30'b0, bus_a.s_valid}, {30'b0, exp_sv});
        chk({tag, "_rdy0"}, {31'b0, bus_a.m_ready}, 32'd0);
        bus_a.s_ready = exp_sv;
        bus_a.s_rdata = {data, data};
        tick();
        bus_a.s_ready = 2'b00;
        bus_a.m_valid = 1'b0;
        chk({tag, "_rdy"}, {31'b0, bus_a.m_ready}, 32'd1);
        chk({tag, "_err"}, {31'b0, bus_a.m_error}, 32'd0);
        chk({tag, "_data"}, bus_a.m_rdata, data);
        tick();
        chk({tag, "_pulse"}, {31'b0, bus_a.m_ready}, 32'd0);
    endtask

    // Unmapped access on dut_a: error response in cycle 1, and no slave is selected.
    task automatic unm_a(input string tag, input logic [31:0] addr);
        bus_a.m_valid = 1'b1; bus_a.m_addr = addr;
        tick();
        bus_a.m_valid = 1'b0;
        chk({tag, "_rdy"}, {31'b0, bus_a.m_ready}, 32'd1);
        chk({tag, "_err"}, {31'b0, bus_a.m_error}, 32'd1);
        chk({tag, "_data"}, bus_a.m_rdata, 32'h0);
        chk({tag, "_sv"}, {30'b0, bus_a.s_valid}, 32'd0);
        tick();
        chk({tag, "_idle"}, {31'b0, bus_a.m_ready}, 32'd0);
    endtask

    initial begin
        bus_a.m_valid = 0; bus_a.m_instr = 0; bus_a.m_addr = 0; bus_a.m_wdata = 0; bus_a.m_wstrb = 0;
        bus_a.s_rdata = '0; bus_a.s_ready = '0;
        bus_b.m_valid = 0; bus_b.m_instr = 0; bus_b.m_addr = 0; bus_b.m_wdata = 0; bus_b.m_wstrb = 0;
        bus_b.s_rdata = '0; bus_b.s_ready = '0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_sv",    {30'b0, bus_a.s_valid}, 32'd0);
        chk("rst_rdy",   {31'b0, bus_a.m_ready}, 32'd0);
        chk("rst_err",   {31'b0, bus_a.m_error}, 32'd0);
        chk("rst_rdata", bus_a.m_rdata, 32'h0);
        chk("rst_addr",  bus_a.s_addr, 32'h0);
        chk("rst_wdata", bus_a.s_wdata, 32'h0);
        chk("rst_wstrb", {28'b0, bus_a.s_wstrb}, 32'd0);
        chk("rst_instr", {31'b0, bus_a.s_instr}, 32'd0);
        chk("rst_b_sv",  {29'b0, bus_b.s_valid}, 32'd0);
        rst = 1'b0;

        // Read 0x80004 from slave 1, ready in its first cycle
        bus_a.m_valid = 1'b1; bus_a.m_instr = 1'b1; bus_a.m_addr = 32'h0008_0004; bus_a.m_wstrb = 4'h0;
        tick();
        chk("rd_sv",    {30'b0, bus_a.s_valid}, 32'd2);
        chk("rd_addr",  bus_a.s_addr, 32'h0008_0004);
        chk("rd_instr", {31'b0, bus_a.s_instr}, 32'd1);
        chk("rd_rdy0",  {31'b0, bus_a.m_ready}, 32'd0);
        bus_a.s_ready = 2'b10; bus_a.s_rdata = {32'hDEAD_BEEF, 32'h0BAD_0BAD};
        tick();
        bus_a.s_ready = 2'b00; bus_a.m_valid = 1'b0; bus_a.m_instr = 1'b0;
        chk("rd_rdy",   {31'b0, bus_a.m_ready}, 32'd1);
        chk("rd_data",  bus_a.m_rdata, 32'hDEAD_BEEF);
        chk("rd_err",   {31'b0, bus_a.m_error}, 32'd0);
        chk("rd_sv_off", {30'b0, bus_a.s_valid}, 32'd0);
        tick();
        chk("rd_pulse", {31'b0, bus_a.m_ready}, 32'd0);

        // Write 0x100 to slave 0, three wait cycles. m_valid drops mid-way and is ignored.
        bus_a.m_valid = 1'b1; bus_a.m_addr = 32'h100; bus_a.m_wdata = 32'h1234; bus_a.m_wstrb = 4'b0011;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("wr_sv",    {30'b0, bus_a.s_valid}, 32'd1);
            chk("wr_wstrb", {28'b0, bus_a.s_wstrb}, 32'h3);
            chk("wr_wdata", bus_a.s_wdata, 32'h1234);
            chk("wr_rdy0",  {31'b0, bus_a.m_ready}, 32'd0);
            if (k == 2) bus_a.m_valid = 1'b0;
            if (k == 4) begin
                bus_a.s_ready = 2'b01; bus_a.s_rdata = {32'h0, 32'h5555_AAAA};
            end
        end
        tick();
        bus_a.s_ready = 2'b00; bus_a.m_wstrb = 4'h0;
        chk("wr_rdy",  {31'b0, bus_a.m_ready}, 32'd1);
        chk("wr_err",  {31'b0, bus_a.m_error}, 32'd0);
        chk("wr_sv_off", {30'b0, bus_a.s_valid}, 32'd0);
        tick();
        chk("wr_pulse", {31'b0, bus_a.m_ready}, 32'd0);

        // Unmapped addresses, including the exclusive top of the last region
        unm_a("unm", 32'h0300_0000);
        unm_a("unm_top", 32'h0010_0000);

        // Region boundaries: top is exclusive, base is inclusive
        rd_a("edge0", 32'h0007_FFFC, 2'b01, 32'h0000_1111);
        rd_a("edge1", 32'h0008_0000, 2'b10, 32'h0000_2222);

        // Timeout: slave 0 never answers. A wrong-slave ready is ignored, and so is a late ready.
        bus_a.m_valid = 1'b1; bus_a.m_addr = 32'h200;
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus_a.s_ready = 2'b00;
            chk("to_sv",   {30'b0, bus_a.s_valid}, 32'd1);
            chk("to_rdy0", {31'b0, bus_a.m_ready}, 32'd0);
            if (k == 3) begin
                bus_a.s_ready = 2'b10; bus_a.s_rdata = {32'h7777_7777, 32'h0};
            end
        end
        tick();
        bus_a.m_valid = 1'b0;
        chk("to_rdy",    {31'b0, bus_a.m_ready}, 32'd1);
        chk("to_err",    {31'b0, bus_a.m_error}, 32'd1);
        chk("to_data",   bus_a.m_rdata, 32'h0);
        chk("to_sv_off", {30'b0, bus_a.s_valid}, 32'd0);
        bus_a.s_ready = 2'b01; bus_a.s_rdata = {32'h0, 32'h9999_9999};
        tick();
        bus_a.s_ready = 2'b00;
        chk("late_rdy", {31'b0, bus_a.m_ready}, 32'd0);
        tick();
        chk("late_rdy2", {31'b0, bus_a.m_ready}, 32'd0);
        chk("late_sv",   {30'b0, bus_a.s_valid}, 32'd0);

        // Reset during the second BUSY cycle aborts the transaction without a response
        bus_a.m_valid = 1'b1; bus_a.m_addr = 32'h0008_0010;
        tick();
        chk("ra_sv1", {30'b0, bus_a.s_valid}, 32'd2);
        tick();
        chk("ra_sv2", {30'b0, bus_a.s_valid}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0; bus_a.m_valid = 1'b0;
        chk("ra_sv",   {30'b0, bus_a.s_valid}, 32'd0);
        chk("ra_rdy",  {31'b0, bus_a.m_ready}, 32'd0);
        chk("ra_addr", bus_a.s_addr, 32'h0);
        tick();
        chk("ra_rdy2", {31'b0, bus_a.m_ready}, 32'd0);
        rd_a("ra_new", 32'h0000_0040, 2'b01, 32'hCAFE_0001);

        // dut_b: overlap (the lowest index wins), the second region, and an empty region
        bus_b.m_valid = 1'b1; bus_b.m_addr = 32'h900;
        tick();
        chk("ov_sv", {29'b0, bus_b.s_valid}, 32'd1);
        bus_b.s_ready = 3'b001; bus_b.s_rdata = {32'h33, 32'h22, 32'h11};
        tick();
        bus_b.s_ready = 3'b000; bus_b.m_valid = 1'b0;
        chk("ov_rdy",  {31'b0, bus_b.m_ready}, 32'd1);
        chk("ov_data", bus_b.m_rdata, 32'h11);
        tick();

        bus_b.m_valid = 1'b1; bus_b.m_addr = 32'h1800;
        tick();
        chk("r1_sv", {29'b0, bus_b.s_valid}, 32'd2);
        bus_b.s_ready = 3'b010;
        tick();
        bus_b.s_ready = 3'b000; bus_b.m_valid = 1'b0;
        chk("r1_rdy",  {31'b0, bus_b.m_ready}, 32'd1);
        chk("r1_data", bus_b.m_rdata, 32'h22);
        tick();

        bus_b.m_valid = 1'b1; bus_b.m_addr = 32'h4800;
        tick();
        bus_b.m_valid = 1'b0;
        chk("empty_rdy", {31'b0, bus_b.m_ready}, 32'd1);
        chk("empty_err", {31'b0, bus_b.m_error}, 32'd1);
        chk("empty_sv",  {29'b0, bus_b.s_valid}, 32'd0);
        tick();
        chk("empty_idle", {31'b0, bus_b.m_ready}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
